// File: rtl/sram_frame_arbiter.sv
// sram_frame_arbiter: round-robin arbiter of N pixel clients onto one pipelined
// ZBT SRAM port, with four rotating frame-buffer roles and a latency-matched
// read-return tag queue.
module sram_frame_arbiter #(
  parameter int N_CLIENTS    = 4,
  parameter int ADDR_W       = 19,
  parameter int DATA_W       = 36,
  parameter int OFF_W        = 17,
  parameter int IMG_WORDS    = 76800,
  parameter int READ_LATENCY = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        frame_flag,
  input  logic [N_CLIENTS-1:0]        req_valid,
  input  logic [N_CLIENTS-1:0]        req_wr,
  input  logic [2*N_CLIENTS-1:0]      req_role,
  input  logic [OFF_W*N_CLIENTS-1:0]  req_offset,
  input  logic [DATA_W*N_CLIENTS-1:0] req_wdata,
  output logic [N_CLIENTS-1:0]        req_ready,
  output logic [N_CLIENTS-1:0]        rd_valid,
  output logic [DATA_W-1:0]           rd_data,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic [7:0]                  buf_map,
  output logic [15:0]                 frame_count
);

  localparam int          ID_W        = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
  localparam int unsigned IMG_WORDS_U = IMG_WORDS;

  // Round-robin pointer and grant
  logic [ID_W-1:0]      rr_q, rr_d;
  logic [ID_W-1:0]      cand;
  logic [ID_W-1:0]      gnt_id;
  logic                 gnt_any;
  logic [N_CLIENTS-1:0] gnt;

  // Selected request fields
  logic                 sel_wr;
  logic [1:0]           sel_role;
  logic [OFF_W-1:0]     sel_off;
  logic [DATA_W-1:0]    sel_wdata;
  logic                 sel_oob;
  logic [1:0]           sel_base;
  logic [ADDR_W-1:0]    sel_addr;

  // SRAM command registers
  logic                 mem_en_q, mem_en_d;
  logic                 mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]    mem_wdata_q, mem_wdata_d;

  // Buffer role map: index 0 CAPT, 1 PROC, 2 NEXD, 3 DISP
  logic [3:0][1:0]      map_q, map_d;
  logic [15:0]          fc_q, fc_d;

  // Read tag queue; stage k lines up with cycle t+1+k after the transfer
  logic [READ_LATENCY:0]           tq_vld_q;
  logic [READ_LATENCY:0][ID_W-1:0] tq_id_q;
  logic [READ_LATENCY:0]           tq_oob_q;
  logic                            tq_push_vld;

  // Read return registers
  logic [N_CLIENTS-1:0] rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]    rd_data_q, rd_data_d;

  // Pick the first valid client starting at the pointer, wrapping around
  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    cand    = '0;
    for (int unsigned k = 0; k < N_CLIENTS; k++) begin
      cand = ID_W'((32'(rr_q) + k) % N_CLIENTS);
      if (!gnt_any && req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_id  = cand;
      end
    end
    if (gnt_any) gnt[gnt_id] = 1'b1;
  end

  assign req_ready = gnt;

  // Mux the granted client's fields and form the SRAM address
  always_comb begin
    sel_wr    = 1'b0;
    sel_role  = '0;
    sel_off   = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < N_CLIENTS; i++) begin
      if (gnt[i]) begin
        sel_wr    = req_wr[i];
        sel_role  = req_role[2*i +: 2];
        sel_off   = req_offset[OFF_W*i +: OFF_W];
        sel_wdata = req_wdata[DATA_W*i +: DATA_W];
      end
    end
    sel_oob  = (32'(sel_off) >= IMG_WORDS_U);
    sel_base = map_q[sel_role];
    sel_addr = ADDR_W'(32'(sel_base) * IMG_WORDS_U + 32'(sel_off));
  end

  // Next-state for pointer, command, role map, frame counter and read return
  always_comb begin
    rr_d = rr_q;
    if (gnt_any) rr_d = ID_W'((32'(gnt_id) + 32'd1) % N_CLIENTS);

    // Out-of-range accesses complete the handshake but never reach the SRAM
    mem_en_d    = gnt_any & ~sel_oob;
    mem_we_d    = gnt_any & sel_wr & ~sel_oob;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (gnt_any && !sel_oob) begin
      mem_addr_d  = sel_addr;
      mem_wdata_d = sel_wdata;
    end

    map_d = map_q;
    fc_d  = fc_q;
    if (frame_flag) begin
      map_d[0] = map_q[3];
      map_d[1] = map_q[0];
      map_d[2] = map_q[1];
      map_d[3] = map_q[2];
      fc_d     = fc_q + 16'd1;
    end

    tq_push_vld = gnt_any & ~sel_wr;

    rd_valid_d = '0;
    rd_data_d  = rd_data_q;
    if (tq_vld_q[READ_LATENCY]) begin
      rd_valid_d[tq_id_q[READ_LATENCY]] = 1'b1;
      rd_data_d = tq_oob_q[READ_LATENCY] ? '0 : mem_rdata;
    end
  end

  // State registers; reset also flushes in-flight read tags
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_q        <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      map_q       <= {2'd3, 2'd2, 2'd1, 2'd0};
      fc_q        <= '0;
      tq_vld_q    <= '0;
      tq_id_q     <= '0;
      tq_oob_q    <= '0;
      rd_valid_q  <= '0;
      rd_data_q   <= '0;
    end else begin
      rr_q        <= rr_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      map_q       <= map_d;
      fc_q        <= fc_d;
      tq_vld_q[0] <= tq_push_vld;
      tq_id_q[0]  <= gnt_id;
      tq_oob_q[0] <= sel_oob;
      for (int unsigned k = 1; k <= READ_LATENCY; k++) begin
        tq_vld_q[k] <= tq_vld_q[k-1];
        tq_id_q[k]  <= tq_id_q[k-1];
        tq_oob_q[k] <= tq_oob_q[k-1];
      end
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign mem_en      = mem_en_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;
  assign buf_map     = {map_q[0], map_q[1], map_q[2], map_q[3]};
  assign frame_count = fc_q;

endmodule

// File: tb/tb_sram_frame_arbiter.sv
// Directed bench for sram_frame_arbiter with a behavioural 2-cycle ZBT SRAM.
module tb_sram_frame_arbiter;

  logic          clock = 1'b0;
  logic          reset;
  logic          frame_flag;
  logic [3:0]    req_valid;
  logic [3:0]    req_wr;
  logic [7:0]    req_role;
  logic [67:0]   req_offset;
  logic [143:0]  req_wdata;
  logic [3:0]    req_ready;
  logic [3:0]    rd_valid;
  logic [35:0]   rd_data;
  logic          mem_en;
  logic          mem_we;
  logic [18:0]   mem_addr;
  logic [35:0]   mem_wdata;
  logic [35:0]   mem_rdata = '0;
  logic [7:0]    buf_map;
  logic [15:0]   frame_count;

  int n_cmp = 0;
  int n_err = 0;

  sram_frame_arbiter #(
    .N_CLIENTS(4), .ADDR_W(19), .DATA_W(36), .OFF_W(17),
    .IMG_WORDS(76800), .READ_LATENCY(2)
  ) dut (
    .clock(clock), .reset(reset), .frame_flag(frame_flag),
    .req_valid(req_valid), .req_wr(req_wr), .req_role(req_role),
    .req_offset(req_offset), .req_wdata(req_wdata), .req_ready(req_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .buf_map(buf_map), .frame_count(frame_count)
  );

  always #5 clock = ~clock;

  // SRAM model: read command seen at edge E gives mem_rdata after edge E+1
  logic [35:0] sram [int];
  logic [35:0] rpipe = '0;
  always @(posedge clock) begin
    if (mem_en && mem_we) sram[int'(mem_addr)] = mem_wdata;
    rpipe     <= (mem_en && !mem_we) ? sram[int'(mem_addr)] : 36'h0;
    mem_rdata <= rpipe;
  end

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int c, input logic wr, input logic [1:0] role,
                         input logic [16:0] off, input logic [35:0] wd);
    req_valid[c]           = 1'b1;
    req_wr[c]              = wr;
    req_role[2*c +: 2]     = role;
    req_offset[17*c +: 17] = off;
    req_wdata[36*c +: 36]  = wd;
  endtask

  task automatic clr;
    req_valid  = '0;
    req_wr     = '0;
    frame_flag = 1'b0;
  endtask

  logic [3:0] seen_rd;

  initial begin
    reset = 1'b1;
    frame_flag = 1'b0;
    req_valid = '0; req_wr = '0; req_role = '0; req_offset = '0; req_wdata = '0;
    sram[76805] = 36'h123;
    tick; tick;
    chk_eq("rst_en", mem_en, 0);
    chk_eq("rst_we", mem_we, 0);
    chk_eq("rst_addr", mem_addr, 0);
    chk_eq("rst_rdv", rd_valid, 0);
    chk_eq("rst_rdd", rd_data, 0);
    chk_eq("rst_map", buf_map, 8'h1B);
    chk_eq("rst_fc", frame_count, 0);
    chk_eq("rst_ready", req_ready, 0);
    reset = 1'b0;
    tick;

    // All four clients writing CAPT continuously: grants 0,1,2,3,0,1
    for (int c = 0; c < 4; c++) set_req(c, 1'b1, 2'd0, 17'(c), 36'(c + 32'hA00));
    for (int i = 0; i < 6; i++) begin
      #1;
      chk_eq("rr_ready", req_ready, 64'(4'b0001 << (i % 4)));
      tick;
      chk_eq("rr_en", mem_en, 1);
      chk_eq("rr_we", mem_we, 1);
      chk_eq("rr_addr", mem_addr, 64'(i % 4));
    end
    clr;
    tick;
    chk_eq("idle_en", mem_en, 0);
    chk_eq("idle_addr_hold", mem_addr, 1);

    // Client1 reads PROC offset 5
    set_req(1, 1'b0, 2'd1, 17'd5, 36'h0);
    #1;
    chk_eq("r1_ready", req_ready, 4'b0010);
    tick;
    clr;
    chk_eq("r1_en", mem_en, 1);
    chk_eq("r1_we", mem_we, 0);
    chk_eq("r1_addr", mem_addr, 76805);
    tick;
    chk_eq("r1_rdv_early1", rd_valid, 0);
    tick;
    chk_eq("r1_rdv_early2", rd_valid, 0);
    tick;
    chk_eq("r1_rdv", rd_valid, 4'b0010);
    chk_eq("r1_rdd", rd_data, 36'h123);
    tick;
    chk_eq("r1_rdv_clear", rd_valid, 0);
    chk_eq("r1_rdd_hold", rd_data, 36'h123);

    // Two back-to-back rotations with client0 CAPT writes
    set_req(0, 1'b1, 2'd0, 17'd0, 36'h55);
    frame_flag = 1'b1;
    tick;
    chk_eq("rot1_addr", mem_addr, 0);
    chk_eq("rot1_en", mem_en, 1);
    chk_eq("rot1_map", buf_map, 8'hC6);
    chk_eq("rot1_fc", frame_count, 1);
    tick;
    frame_flag = 1'b0;
    chk_eq("rot2_addr", mem_addr, 230400);
    chk_eq("rot2_map", buf_map, 8'hB1);
    chk_eq("rot2_fc", frame_count, 2);
    clr;
    tick;

    // Client2 reads out of range: no SRAM access, returns zero
    set_req(2, 1'b0, 2'd1, 17'd76800, 36'h0);
    #1;
    chk_eq("oob_ready", req_ready, 4'b0100);
    tick;
    clr;
    chk_eq("oob_en", mem_en, 0);
    chk_eq("oob_addr_hold", mem_addr, 230400);
    tick; tick;
    chk_eq("oob_rdv_early", rd_valid, 0);
    tick;
    chk_eq("oob_rdv", rd_valid, 4'b0100);
    chk_eq("oob_rdd", rd_data, 0);

    // Read after write through NEXD (buffer 0 now)
    set_req(0, 1'b1, 2'd2, 17'd10, 36'hABC);
    tick;
    clr;
    chk_eq("raw_w_en", mem_en, 1);
    chk_eq("raw_w_we", mem_we, 1);
    chk_eq("raw_w_addr", mem_addr, 10);
    chk_eq("raw_w_data", mem_wdata, 36'hABC);
    set_req(1, 1'b0, 2'd2, 17'd10, 36'h0);
    tick;
    clr;
    chk_eq("raw_r_we", mem_we, 0);
    chk_eq("raw_r_addr", mem_addr, 10);
    tick; tick; tick;
    chk_eq("raw_rdv", rd_valid, 4'b0010);
    chk_eq("raw_rdd", rd_data, 36'hABC);

    // Back-to-back reads from clients 3 then 0, reset while in flight
    set_req(0, 1'b0, 2'd3, 17'd1, 36'h0);
    set_req(3, 1'b0, 2'd3, 17'd2, 36'h0);
    #1;
    chk_eq("b2b_ready0", req_ready, 4'b1000);
    tick;
    #1;
    chk_eq("b2b_ready1", req_ready, 4'b0001);
    tick;
    clr;
    reset = 1'b1;
    #1;
    chk_eq("arst_en", mem_en, 0);
    chk_eq("arst_addr", mem_addr, 0);
    chk_eq("arst_wdata", mem_wdata, 0);
    chk_eq("arst_rdd", rd_data, 0);
    chk_eq("arst_map", buf_map, 8'h1B);
    chk_eq("arst_fc", frame_count, 0);
    tick;
    reset = 1'b0;
    seen_rd = '0;
    for (int i = 0; i < 6; i++) begin
      tick;
      seen_rd = seen_rd | rd_valid;
    end
    chk_eq("arst_no_rdv", seen_rd, 0);
    req_valid = 4'b1001;
    #1;
    chk_eq("arst_rr", req_ready, 4'b0001);
    clr;
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
